// File: rtl/shift_sequencer.sv
// Purpose : multi-cycle ARM shifter-operand unit; STEP bit positions per SHIFT cycle
//           through a 33-bit working register (32 data bits plus the carry bit).
// Latency : out_valid rises max(1, ceil(n/STEP)) cycles after the accepting edge.
// Backpr. : one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid/in_ready           request handshake; in_op (LSL/LSR/ASR/ROR), in_imm,
//                               in_amt, in_data, in_cin are sampled on acceptance
//   out_valid/out_ready         result handshake; out_data, out_cout held while in DONE
//   busy                        high while an operation is in SHIFT or DONE
module shift_sequencer #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic        in_imm,
  input  logic [7:0]  in_amt,
  input  logic [31:0] in_data,
  input  logic        in_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_cout,
  output logic        busy
);

  localparam logic [1:0] OP_LSL = 2'd0;
  localparam logic [1:0] OP_LSR = 2'd1;
  localparam logic [1:0] OP_ASR = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;
  localparam logic [5:0] STEP_W = 6'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        carry_q, carry_d;
  logic [1:0]  op_q, op_d;
  logic        rorc_q, rorc_d;   // carry-out comes from result[31] (real rotate)
  logic [5:0]  rem_q, rem_d;     // positions still to shift, 0..33
  logic [31:0] res_q, res_d;
  logic        cout_q, cout_d;

  // Acceptance decode: effective count and preloaded working register.
  // Special cases (passthrough, RRX, ROR by a multiple of 32) are folded into
  // the preload with n=0, so they flow through one SHIFT cycle unchanged.
  logic [31:0] acc_data;
  logic        acc_carry;
  logic [5:0]  acc_n;
  logic        acc_rorc;
  logic [4:0]  amt5;

  always_comb begin
    acc_data  = in_data;
    acc_carry = in_cin;
    acc_n     = 6'd0;
    acc_rorc  = 1'b0;
    amt5      = in_amt[4:0];
    if (!in_imm) begin
      if (in_amt == 8'd0) begin
        // passthrough with current C flag
      end else if (in_op != OP_ROR) begin
        // any count beyond 32 behaves like 33: everything shifted out
        acc_n = (in_amt > 8'd33) ? 6'd33 : in_amt[5:0];
      end else if (amt5 == 5'd0) begin
        acc_carry = in_data[31];
      end else begin
        acc_n    = {1'b0, amt5};
        acc_rorc = 1'b1;
      end
    end else if (amt5 != 5'd0) begin
      acc_n    = {1'b0, amt5};
      acc_rorc = (in_op == OP_ROR);
    end else begin
      case (in_op)
        OP_LSR, OP_ASR: acc_n = 6'd32;
        OP_ROR: begin
          acc_data  = {in_cin, in_data[31:1]};
          acc_carry = in_data[0];
        end
        default: ;
      endcase
    end
  end

  // One shift stage of at most STEP positions.
  logic [5:0]  k;
  logic [32:0] lsl_w, lsr_w, asr_w;
  logic [63:0] ror_w;
  logic [31:0] sh_data;
  logic        sh_carry;

  always_comb begin
    k     = (rem_q > STEP_W) ? STEP_W : rem_q;
    lsl_w = {carry_q, data_q} << k;           // carry sits above bit 31
    lsr_w = {data_q, carry_q} >> k;           // carry sits below bit 0
    asr_w = 33'($signed({data_q, carry_q}) >>> k);
    ror_w = {data_q, data_q} >> k;
    sh_data  = data_q;
    sh_carry = carry_q;
    case (op_q)
      OP_LSL: begin sh_data = lsl_w[31:0];  sh_carry = lsl_w[32]; end
      OP_LSR: begin sh_data = lsr_w[32:1];  sh_carry = lsr_w[0];  end
      OP_ASR: begin sh_data = asr_w[32:1];  sh_carry = asr_w[0];  end
      default: begin sh_data = ror_w[31:0]; sh_carry = carry_q;   end
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    op_d    = op_q;
    rorc_d  = rorc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = acc_data;
          carry_d = acc_carry;
          op_d    = in_op;
          rorc_d  = acc_rorc;
          rem_d   = acc_n;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d  = sh_data;
        carry_d = sh_carry;
        rem_d   = rem_q - k;
        if (rem_q == k) begin
          state_d = DONE;
          res_d   = sh_data;
          cout_d  = rorc_q ? sh_data[31] : sh_carry;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 32'd0;
      carry_q <= 1'b0;
      op_q    <= OP_LSL;
      rorc_q  <= 1'b0;
      rem_q   <= 6'd0;
      res_q   <= 32'd0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      rorc_q  <= rorc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_imm;
  logic [7:0]  in_amt;
  logic [31:0] in_data;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_cout;
  logic        busy;

  shift_sequencer #(.STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_amt(in_amt), .in_data(in_data), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cout(out_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        c;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   hold_n = 0;
  bit   seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ARM shifter-operand semantics, written from the architectural rules.
  task automatic model(input logic [1:0] op, input logic imm, input logic [7:0] amt,
                       input logic [31:0] d, input logic cin,
                       output logic [31:0] r, output logic co, output int n);
    int s;
    int rot;
    s = imm ? int'(amt[4:0]) : int'(amt);
    if (imm && s == 0 && (op == 2'd1 || op == 2'd2)) s = 32;
    r = d; co = cin; n = 0;
    if (op != 2'd3) n = (s > 33) ? 33 : s;
    case (op)
      2'd0: begin
        if (s == 0) begin r = d; co = cin; end
        else if (s < 32) begin r = d << s; co = d[32 - s]; end
        else if (s == 32) begin r = 0; co = d[0]; end
        else begin r = 0; co = 1'b0; end
      end
      2'd1: begin
        if (s == 0) begin r = d; co = cin; end
        else if (s < 32) begin r = d >> s; co = d[s - 1]; end
        else if (s == 32) begin r = 0; co = d[31]; end
        else begin r = 0; co = 1'b0; end
      end
      2'd2: begin
        if (s == 0) begin r = d; co = cin; end
        else if (s < 32) begin r = 32'($signed(d) >>> s); co = d[s - 1]; end
        else begin r = {32{d[31]}}; co = d[31]; end
      end
      default: begin
        if (imm && s == 0) begin r = {cin, d[31:1]}; co = d[0]; end
        else if (s == 0) begin r = d; co = cin; end
        else begin
          rot = s % 32;
          if (rot == 0) begin r = d; co = d[31]; end
          else begin r = (d >> rot) | (d << (32 - rot)); co = r[31]; n = rot; end
        end
      end
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic imm, input logic [7:0] amt,
                      input logic [31:0] d, input logic cin);
    exp_t e;
    int   n;
    bit   done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        in_op = op; in_imm = imm; in_amt = amt; in_data = d; in_cin = cin;
        in_valid = 1'b1;
        model(op, imm, amt, d, cin, e.d, e.c, n);
        e.lat = (n == 0) ? 1 : (n + STEP - 1) / STEP;
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        done = 1;
      end else begin
        // garbage while busy must be ignored
        in_valid = 1'($urandom_range(0, 1));
        in_op = 2'($urandom); in_imm = 1'($urandom); in_amt = 8'($urandom);
        in_data = $urandom; in_cin = 1'($urandom);
      end
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(posedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor / scoreboard
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        continue;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          chk("out_data", 64'(out_data), 64'(sb[0].d));
          chk("out_cout", 64'(out_cout), 64'(sb[0].c));
          chk("in_ready_in_done", 64'(in_ready), 64'd0);
          if (!seen) begin
            chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            chk("busy_in_done", 64'(busy), 64'd1);
            seen = 1;
          end
        end
      end
      if (hold_n > 0 && out_valid) begin
        out_ready = 1'b0;
        hold_n--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        seen = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_imm = 1'b0;
    in_amt = 8'd0; in_data = 32'd0; in_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_cout", 64'(out_cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    hold_n = 3;
    send(2'd2, 1'b0, 8'd4,   32'h800000F0, 1'b0);
    send(2'd0, 1'b0, 8'd32,  32'h00000001, 1'b0);
    send(2'd1, 1'b0, 8'd40,  32'hFFFFFFFF, 1'b1);
    send(2'd2, 1'b0, 8'd200, 32'h80000000, 1'b0);
    send(2'd3, 1'b1, 8'd0,   32'h00000003, 1'b1);
    send(2'd3, 1'b0, 8'd36,  32'h000000F1, 1'b1);
    send(2'd3, 1'b0, 8'd32,  32'h80000000, 1'b0);
    send(2'd1, 1'b0, 8'd0,   32'h12345678, 1'b1);
    send(2'd1, 1'b1, 8'd0,   32'h80000001, 1'b0);
    send(2'd0, 1'b1, 8'd0,   32'hCAFEF00D, 1'b1);
    hold_n = 3;
    send(2'd2, 1'b1, 8'd0,   32'h40000000, 1'b1);

    // randomized
    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 4))
        0: a = 8'd0;
        1: a = 8'(32 + $urandom_range(0, 1));
        2: a = 8'($urandom_range(1, 31));
        3: a = 8'($urandom);
        default: a = 8'(32 * $urandom_range(1, 7));
      endcase
      send(2'($urandom), 1'($urandom), a, $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // async reset in the middle of a shift
    send(2'd0, 1'b0, 8'd32, 32'h00000001, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_out_cout", 64'(out_cout), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd2, 1'b0, 8'd4, 32'h800000F0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
